// File: rtl/trace_pkg.sv
// Shared types for the write-back trace capture stage: entry kinds and the packed trace entry.
package trace_pkg;

  localparam logic KIND_GRF = 1'b0;
  localparam logic KIND_DM  = 1'b1;

  typedef struct packed {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_entry_t;

endpackage

// File: rtl/wb_trace_fifo_if.sv
// Core-side write strobes, consumer-side trace stream and status of the trace FIFO.
interface wb_trace_fifo_if #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 16
) ();

  localparam int unsigned CountW = $clog2(DEPTH) + 1;

  logic [31:0]       pc;
  logic              grf_we;
  logic [4:0]        grf_addr;
  logic [31:0]       grf_wdata;
  logic              dm_we;
  logic [31:0]       dm_addr;
  logic [31:0]       dm_wdata;

  logic              out_valid;
  logic              out_ready;
  logic              out_kind;
  logic [31:0]       out_pc;
  logic [31:0]       out_addr;
  logic [31:0]       out_data;

  logic [CountW-1:0] count;
  logic              overflow;
  logic [CNT_W-1:0]  drop_cnt;

  modport master (
    output pc, grf_we, grf_addr, grf_wdata, dm_we, dm_addr, dm_wdata, out_ready,
    input  out_valid, out_kind, out_pc, out_addr, out_data, count, overflow, drop_cnt
  );

  modport slave (
    input  pc, grf_we, grf_addr, grf_wdata, dm_we, dm_addr, dm_wdata, out_ready,
    output out_valid, out_kind, out_pc, out_addr, out_data, count, overflow, drop_cnt
  );

endinterface

// File: rtl/trace_fifo_2w1r.sv
// In-order FIFO with two write ports (port 0 is older) and one read port; the caller never
// writes more entries than there are free slots.
module trace_fifo_2w1r #(
  parameter int unsigned DEPTH = 16,
  parameter type entry_t = trace_pkg::trace_entry_t
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en0,
  input  entry_t                   wr_data0,
  input  logic                     wr_en1,
  input  entry_t                   wr_data1,
  input  logic                     rd_en,
  output entry_t                   head,
  output entry_t                   last,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AddrW = $clog2(DEPTH);

  entry_t           mem_q [DEPTH];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddrW-1:0] wr_addr1, last_ptr;
  logic [AddrW:0]   count_q, count_d;

  always_comb begin
    wr_addr1 = wr_ptr_q + AddrW'(wr_en0);
    wr_ptr_d = wr_ptr_q + AddrW'(wr_en0) + AddrW'(wr_en1);
    rd_ptr_d = rd_ptr_q + AddrW'(rd_en);
    count_d  = count_q + (AddrW+1)'(wr_en0) + (AddrW+1)'(wr_en1) - (AddrW+1)'(rd_en);
    // Slot behind the read pointer holds the last popped entry; writes cannot reach it
    // while the FIFO is empty because DEPTH >= 4.
    last_ptr = rd_ptr_q - AddrW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (wr_en0) mem_q[wr_ptr_q] <= wr_data0;
      if (wr_en1) mem_q[wr_addr1] <= wr_data1;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign last  = mem_q[last_ptr];
  assign count = count_q;

endmodule

// File: rtl/wb_trace_fifo.sv
// Write-back trace capture: filters GRF/DM write strobes into trace entries (DM before GRF),
// buffers them in order and accounts for entries dropped when the FIFO is full.
module wb_trace_fifo
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  wb_trace_fifo_if.slave  bus
);

  localparam int unsigned AddrW = $clog2(DEPTH);

  logic             dm_ev, grf_ev, out_valid, pop;
  logic [AddrW:0]   count, free;
  logic             wr_en0, wr_en1;
  trace_entry_t     dm_entry, grf_entry, wr_data0, wr_data1, head, last, shown;
  logic [1:0]       n_ev, n_wr, n_drop;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W:0]   drop_sum;

  always_comb begin
    dm_ev  = bus.dm_we;
    grf_ev = bus.grf_we && (bus.grf_addr != 5'd0);

    dm_entry  = '{kind: KIND_DM, pc: bus.pc, addr: bus.dm_addr, data: bus.dm_wdata};
    grf_entry = '{kind: KIND_GRF, pc: bus.pc, addr: {27'd0, bus.grf_addr},
                  data: bus.grf_wdata};

    out_valid = (count != '0);
    pop       = out_valid && bus.out_ready;
    free      = (AddrW+1)'(DEPTH) - count + (AddrW+1)'(pop);

    // Port 0 takes the first event in DM-then-GRF order, so a single free slot keeps DM.
    wr_data0 = dm_ev ? dm_entry : grf_entry;
    wr_data1 = grf_entry;
    wr_en0   = (dm_ev || grf_ev) && (free != '0);
    wr_en1   = dm_ev && grf_ev && (free > (AddrW+1)'(1));

    n_ev   = {1'b0, dm_ev} + {1'b0, grf_ev};
    n_wr   = {1'b0, wr_en0} + {1'b0, wr_en1};
    n_drop = n_ev - n_wr;

    overflow_d = overflow_q || (n_drop != 2'd0);
    drop_sum   = {1'b0, drop_cnt_q} + (CNT_W+1)'(n_drop);
    drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];

    shown = out_valid ? head : last;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  trace_fifo_2w1r #(
    .DEPTH   (DEPTH),
    .entry_t (trace_entry_t)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en0   (wr_en0),
    .wr_data0 (wr_data0),
    .wr_en1   (wr_en1),
    .wr_data1 (wr_data1),
    .rd_en    (pop),
    .head     (head),
    .last     (last),
    .count    (count)
  );

  assign bus.out_valid = out_valid;
  assign bus.out_kind  = shown.kind;
  assign bus.out_pc    = shown.pc;
  assign bus.out_addr  = shown.addr;
  assign bus.out_data  = shown.data;
  assign bus.count     = count;
  assign bus.overflow  = overflow_q;
  assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Bench for wb_trace_fifo: directed scenarios plus random traffic against a queue-based model.
module tb_wb_trace_fifo;
  import trace_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = 16;

  logic clk;
  logic reset;

  wb_trace_fifo_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  wb_trace_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending entries, last head shown, sticky flag, drop count.
  trace_entry_t     mq[$];
  trace_entry_t     shown;
  bit               m_ov;
  logic [CNT_W-1:0] m_drops;

  int n_checks;
  int n_pass;

  function automatic logic [119:0] observed();
    return {bus.out_valid, bus.out_kind, bus.out_pc, bus.out_addr, bus.out_data,
            bus.count, bus.overflow, bus.drop_cnt};
  endfunction

  function automatic logic [119:0] expected();
    trace_entry_t h;
    h = (mq.size() != 0) ? mq[0] : shown;
    return {mq.size() != 0, h, 5'(mq.size()), m_ov, m_drops};
  endfunction

  task automatic model_reset();
    mq.delete();
    shown   = '0;
    m_ov    = 1'b0;
    m_drops = '0;
  endtask

  task automatic set_ev(input bit dm, input bit grf, input logic [4:0] ga);
    bus.pc        = $urandom & 32'hFFFF_FFFC;
    bus.dm_we     = dm;
    bus.dm_addr   = $urandom;
    bus.dm_wdata  = $urandom;
    bus.grf_we    = grf;
    bus.grf_addr  = ga;
    bus.grf_wdata = $urandom;
  endtask

  task automatic model_push(input trace_entry_t e, inout int free);
    if (free > 0) begin
      mq.push_back(e);
      free--;
    end else begin
      m_ov = 1'b1;
      if (m_drops != '1) m_drops++;
    end
  endtask

  // One clock: apply the current inputs to model and DUT, end at the following falling edge.
  task automatic step();
    bit           pop, dm_ev, grf_ev;
    int           free;
    trace_entry_t de, ge;
    pop    = (mq.size() != 0) && bus.out_ready;
    free   = DEPTH - mq.size() + int'(pop);
    dm_ev  = bus.dm_we;
    grf_ev = bus.grf_we && (bus.grf_addr != 0);
    de     = '{kind: KIND_DM, pc: bus.pc, addr: bus.dm_addr, data: bus.dm_wdata};
    ge     = '{kind: KIND_GRF, pc: bus.pc, addr: 32'(bus.grf_addr), data: bus.grf_wdata};
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (dm_ev) model_push(de, free);
    if (grf_ev) model_push(ge, free);
    if (mq.size() != 0) shown = mq[0];
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.out_ready = 1'b0;
    set_ev(1'b0, 1'b0, 5'd0);
    model_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (observed() !== 120'd0) $display("FAIL reset_held got=%h want=%h", observed(), 120'd0);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (observed() !== expected())
      $display("FAIL reset_release got=%h want=%h", observed(), expected());
    else n_pass++;
  endtask

  task automatic test_single_grf();
    bus.out_ready = 1'b1;
    set_ev(1'b0, 1'b1, 5'd8);
    bus.grf_wdata = 32'h1234;
    bus.pc        = 32'h3000;
    step();
    n_checks++;
    if (!(bus.out_valid === 1'b1 && bus.out_kind === KIND_GRF && bus.out_addr === 32'd8 &&
          bus.out_data === 32'h1234 && bus.out_pc === 32'h3000))
      $display("FAIL single_grf_head got=%h want=v1 GRF pc 3000 addr 8 data 1234", observed());
    else n_pass++;
    n_checks++;
    if (observed() !== expected())
      $display("FAIL single_grf_model got=%h want=%h", observed(), expected());
    else n_pass++;
    set_ev(1'b0, 1'b0, 5'd0);
    step();
    n_checks++;
    if (bus.count !== 5'd0 || bus.out_valid !== 1'b0 || observed() !== expected())
      $display("FAIL single_grf_drain got=%h want=%h", observed(), expected());
    else n_pass++;
  endtask

  task automatic test_r0_filter();
    set_ev(1'b0, 1'b1, 5'd0);
    step();
    n_checks++;
    if (bus.count !== 5'd0 || bus.out_valid !== 1'b0 || observed() !== expected())
      $display("FAIL r0_filter got=%h want=%h", observed(), expected());
    else n_pass++;
    set_ev(1'b0, 1'b0, 5'd0);
  endtask

  task automatic test_dual_order();
    bus.out_ready = 1'b0;
    set_ev(1'b1, 1'b1, 5'd3);
    bus.dm_addr   = 32'h4;
    bus.dm_wdata  = 32'hAB;
    bus.grf_wdata = 32'hCD;
    step();
    n_checks++;
    if (bus.count !== 5'd2 || bus.out_kind !== KIND_DM || bus.out_addr !== 32'h4 ||
        bus.out_data !== 32'hAB || observed() !== expected())
      $display("FAIL dual_dm_first got=%h want=%h", observed(), expected());
    else n_pass++;
    set_ev(1'b0, 1'b0, 5'd0);
    bus.out_ready = 1'b1;
    step();
    n_checks++;
    if (bus.count !== 5'd1 || bus.out_kind !== KIND_GRF || bus.out_addr !== 32'd3 ||
        bus.out_data !== 32'hCD || observed() !== expected())
      $display("FAIL dual_grf_second got=%h want=%h", observed(), expected());
    else n_pass++;
    step();
    n_checks++;
    if (bus.count !== 5'd0 || observed() !== expected())
      $display("FAIL dual_drained got=%h want=%h", observed(), expected());
    else n_pass++;
  endtask

  task automatic test_overflow();
    bit dm;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      dm = bit'($urandom_range(0, 1));
      set_ev(dm, !dm, 5'($urandom_range(1, 31)));
      step();
    end
    set_ev(1'b0, 1'b0, 5'd0);
    n_checks++;
    if (bus.count !== 5'd16 || bus.overflow !== 1'b1 || bus.drop_cnt !== 16'd1)
      $display("FAIL overflow_flags got cnt=%0d ov=%0d drops=%0d want cnt=16 ov=1 drops=1",
               bus.count, bus.overflow, bus.drop_cnt);
    else n_pass++;
    n_checks++;
    if (observed() !== expected())
      $display("FAIL overflow_model got=%h want=%h", observed(), expected());
    else n_pass++;
  endtask

  task automatic test_full_pop_push();
    bus.out_ready = 1'b1;
    set_ev(1'b0, 1'b1, 5'd5);
    step();
    n_checks++;
    if (bus.count !== 5'd16 || bus.drop_cnt !== 16'd1 || observed() !== expected())
      $display("FAIL full_pop_push got=%h want=%h", observed(), expected());
    else n_pass++;
    // Full with a pop: one free slot, so DM is kept and GRF dropped.
    set_ev(1'b1, 1'b1, 5'd7);
    step();
    n_checks++;
    if (bus.count !== 5'd16 || bus.drop_cnt !== 16'd2 || observed() !== expected())
      $display("FAIL full_dual_one_slot got=%h want=%h", observed(), expected());
    else n_pass++;
    set_ev(1'b0, 1'b0, 5'd0);
    for (int i = 0; i < 16; i++) begin
      step();
      n_checks++;
      if (observed() !== expected())
        $display("FAIL drain_%0d got=%h want=%h", i, observed(), expected());
      else n_pass++;
    end
    n_checks++;
    if (bus.count !== 5'd0 || bus.out_valid !== 1'b0)
      $display("FAIL drain_empty got cnt=%0d v=%0d want 0 0", bus.count, bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [4:0] ga;
    for (int i = 0; i < 400; i++) begin
      bus.out_ready = (i < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
      ga = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      set_ev(bit'($urandom_range(0, 1)), ($urandom_range(0, 4) < 3), ga);
      step();
      n_checks++;
      if (observed() !== expected())
        $display("FAIL random_%0d got=%h want=%h", i, observed(), expected());
      else n_pass++;
    end
    set_ev(1'b0, 1'b0, 5'd0);
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b1;
    repeat (20) step();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_ev(1'b0, 1'b1, 5'($urandom_range(1, 31)));
      step();
    end
    set_ev(1'b0, 1'b0, 5'd0);
    bus.out_ready = 1'b1;
    repeat (3) step();
    n_checks++;
    if (bus.count !== 5'd5 || observed() !== expected())
      $display("FAIL pre_reset got=%h want=%h", observed(), expected());
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.count !== 5'd0 || bus.overflow !== 1'b0 ||
        bus.drop_cnt !== 16'd0 || observed() !== 120'd0)
      $display("FAIL async_reset got=%h want=%h", observed(), 120'd0);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    set_ev(1'b1, 1'b0, 5'd0);
    step();
    n_checks++;
    if (observed() !== expected())
      $display("FAIL after_reset got=%h want=%h", observed(), expected());
    else n_pass++;
    set_ev(1'b0, 1'b0, 5'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_single_grf();
    test_r0_filter();
    test_dual_order();
    test_overflow();
    test_full_pop_push();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_trace_fifo.md
# wb_trace_fifo

Write-back trace capture stage that sits directly downstream of the `mips` core, between the core and the simulation checker/testbench. Every cycle it samples the core's register-file (GRF) and data-memory (DM) write strobes, packs each architectural write into a trace entry tagged with its PC, and buffers the entries in an in-order FIFO. A downstream consumer drains the FIFO through a valid/ready handshake. The block exists so that traces can be compared against the reference simulator's `@pc: $r <= v` / `@pc: *addr <= v` log without stalling the core.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, at least 4.
- `CNT_W`, 16: width of the drop counter.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; 0 clears all state.
- `pc` in 32: PC of the instruction retiring this cycle.
- `grf_we` in 1: GRF write strobe.
- `grf_addr` in 5: GRF destination register.
- `grf_wdata` in 32: GRF write data.
- `dm_we` in 1: DM write strobe.
- `dm_addr` in 32: DM byte address.
- `dm_wdata` in 32: DM write data.
- `out_valid` out 1: head entry is present.
- `out_ready` in 1: consumer accepts the head entry.
- `out_kind` out 1: 0 = GRF, 1 = DM.
- `out_pc` out 32: PC of the head entry.
- `out_addr` out 32: register number (zero-extended) or memory address.
- `out_data` out 32: written value.
- `count` out $clog2(DEPTH)+1: current occupancy.
- `overflow` out 1: sticky; set when an event is dropped.
- `drop_cnt` out CNT_W: number of dropped events; saturates at its maximum value.

## Operation
- Event generation:
  - A GRF event is raised when `grf_we && grf_addr != 0`. Writes to `$0` are never logged.
  - A DM event is raised when `dm_we`.
- Both events in the same cycle produce two entries, DM first, then GRF. The order is fixed.
- Free slots for this cycle = `DEPTH - count + pop`, where `pop = out_valid && out_ready`. A push therefore succeeds on a full FIFO if a pop happens in the same cycle.
- When two events arrive and only one slot is free, the DM entry is stored and the GRF entry is dropped.
- Every dropped event sets `overflow` and increments `drop_cnt` (saturating). Two drops in one cycle add 2.
- Entries leave in FIFO order. Head outputs are stable while `out_valid && !out_ready`.
- When the FIFO is empty, `out_valid` = 0 and the `out_*` fields hold their previous values.
- Read and write pointers are `$clog2(DEPTH)` bits wide and wrap modulo DEPTH. Full/empty is decided from `count`.
- Reset (asynchronous, at any time) behaves as follows:
  - Pointers, `count`, `overflow` and `drop_cnt` go to 0.
  - `out_valid` goes to 0, and every `out_*` field goes to 0.
  - Entries in flight are discarded.
  - There is no event capture while `reset` = 0.

## Timing
- Capture latency: an event sampled at rising edge n appears at the head with `out_valid` = 1 after edge n, provided the FIFO was empty. No combinational path exists from the event inputs to `out_*`.
- Pop takes effect at the edge where `out_valid && out_ready`. The next entry is presented after that same edge.
- `count` updates by `+pushes - pop` at each edge; it may change by -1, 0, +1 or +2.
- `out_ready` may be held high permanently. The sustained drain rate is one entry per cycle.
- `overflow` and `drop_cnt` update at the same edge as the dropped push.

## Structure
- Shared package `trace_pkg` holds:
  - `KIND_GRF` = 1'b0 and `KIND_DM` = 1'b1.
  - The packed `trace_entry_t` struct: {kind, pc[31:0], addr[31:0], data[31:0]}, 97 bits.
- Natural sub-module: `trace_fifo_2w1r`, a FIFO with two write ports and one read port, parameterised on DEPTH and entry type.
- The top level holds event filtering, DM/GRF ordering, drop accounting and the handshake outputs.

## Test plan
- Reset release, then `grf_we`=1, `grf_addr`=8, `grf_wdata`=0x1234, `pc`=0x3000, `out_ready`=1 → one cycle later `out_valid`=1, kind=GRF, `out_addr`=8, `out_data`=0x1234, `out_pc`=0x3000; `count` returns to 0.
- `grf_we`=1 with `grf_addr`=0 → no entry; `count` stays 0 and `out_valid` stays 0.
- In one cycle, `dm_we` with `dm_addr`=0x4, `dm_wdata`=0xAB, plus `grf_we` with `grf_addr`=3 and `grf_wdata`=0xCD → `count`=2; the DM entry drains before the GRF entry.
- With `out_ready`=0, push 17 single events (DEPTH=16) → `count`=16, `overflow`=1, `drop_cnt`=1; draining returns the first 16 events in order.
- With the FIFO full, `out_ready`=1 and one event in the same cycle → the event is accepted, `count` stays 16, and `drop_cnt` is unchanged.
- Assert `reset`=0 mid-drain with `count`=5 → immediately `out_valid`=0, `count`=0, `overflow`=0 and `drop_cnt`=0, without waiting for a clock edge.
